// File: rtl/pe_inv.sv
// pe_inv: inverse radix-2 butterfly (twiddle multiply first, then add/sub) on sign-magnitude operands, 3-stage valid/ready pipeline.
// Optional macro PE_INV_SCALE_EN: every add/sub result is halved (one guard bit, truncated), so only the multiply can saturate.
module pe_inv #(
    parameter int WL  = 16,
    parameter int FWL = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in0,
    input  logic [WL-1:0] in1,
    input  logic [WL-1:0] in2,
    input  logic [WL-1:0] in3,
    input  logic [WL-1:0] twiddle,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out0,
    output logic [WL-1:0] out1,
    output logic [WL-1:0] out2,
    output logic [WL-1:0] out3,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int MW = WL - 1;
    localparam int PW = 2 * MW;

    // Both arithmetic helpers return {saturated, sign, magnitude}; zero magnitude always carries a + sign.
    function automatic logic [WL:0] q_mul(input logic [WL-1:0] a, input logic [WL-1:0] b);
        logic [PW-1:0]     prod;
        logic [PW-FWL-1:0] shifted;
        logic [MW-1:0]     mag;
        logic              sat;
        prod    = PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
        shifted = prod[PW-1:FWL];
        sat     = |shifted[PW-FWL-1:MW];
        mag     = sat ? {MW{1'b1}} : shifted[MW-1:0];
        return {sat, (a[WL-1] ^ b[WL-1]) & (|mag), mag};
    endfunction

    function automatic logic [WL:0] q_add(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                          input logic neg_b);
        logic          sb;
        logic [MW:0]   sum;
        logic [MW-1:0] mag;
        logic          sgn;
        logic          sat;
        sb  = b[WL-1] ^ neg_b;
        sat = 1'b0;
        if (a[WL-1] == sb) begin
            sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
            sgn = sb;
        end else if (a[MW-1:0] >= b[MW-1:0]) begin
            sum = {1'b0, a[MW-1:0] - b[MW-1:0]};
            sgn = a[WL-1];
        end else begin
            sum = {1'b0, b[MW-1:0] - a[MW-1:0]};
            sgn = sb;
        end
`ifdef PE_INV_SCALE_EN
        mag = MW'(sum >> 1);
`else
        sat = sum[MW];
        mag = sat ? {MW{1'b1}} : sum[MW-1:0];
`endif
        return {sat, sgn & (|mag), mag};
    endfunction

    logic          en;
    logic          s1_valid_reg;
    logic          s2_valid_reg;
    logic          s3_valid_reg;
    logic [WL-1:0] s1_reg [5];      // in0, in1, in2, in3, twiddle
    logic [WL-1:0] s2_reg [4];      // in0, t1, in2, t3
    logic [WL-1:0] s3_reg [4];
    logic          ovf_reg;
    logic [WL-1:0] in_word [5];
    logic [WL-1:0] s2_next [4];
    logic [WL:0]   mul_res [2];
    logic [WL:0]   add_res [4];
    logic          mul_sat;
    logic          add_sat;
    logic          ovf_set;

    assign en       = !s3_valid_reg || out_ready;
    assign in_ready = en;

    assign in_word[0] = in0;
    assign in_word[1] = in1;
    assign in_word[2] = in2;
    assign in_word[3] = in3;
    assign in_word[4] = twiddle;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mul
            assign mul_res[gi]      = q_mul(s1_reg[2*gi+1], s1_reg[4]);
            assign s2_next[2*gi]    = s1_reg[2*gi];
            assign s2_next[2*gi+1]  = mul_res[gi][WL-1:0];
        end
        // Lanes 0/1 add, lanes 2/3 subtract; even lanes use the in0 pair, odd lanes the in2 pair.
        for (gi = 0; gi < 4; gi++) begin : g_add
            assign add_res[gi] = q_add(s2_reg[2*(gi%2)], s2_reg[2*(gi%2)+1], (gi >= 2));
        end
    endgenerate

    assign mul_sat = mul_res[0][WL] | mul_res[1][WL];
    assign add_sat = add_res[0][WL] | add_res[1][WL] | add_res[2][WL] | add_res[3][WL];
    assign ovf_set = en && ((s1_valid_reg && mul_sat) || (s2_valid_reg && add_sat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            for (int i = 0; i < 5; i++) s1_reg[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                s2_reg[i] <= '0;
                s3_reg[i] <= '0;
            end
        end else begin
            if (en) begin
                s1_valid_reg <= in_valid;
                s2_valid_reg <= s1_valid_reg;
                s3_valid_reg <= s2_valid_reg;
                if (in_valid)     for (int i = 0; i < 5; i++) s1_reg[i] <= in_word[i];
                if (s1_valid_reg) for (int i = 0; i < 4; i++) s2_reg[i] <= s2_next[i];
                if (s2_valid_reg) for (int i = 0; i < 4; i++) s3_reg[i] <= add_res[i][WL-1:0];
            end
            // A new saturation outranks a simultaneous clear.
            ovf_reg <= (ovf_reg && !ovf_clr) || ovf_set;
        end
    end

    assign out_valid = s3_valid_reg;
    assign out0      = s3_reg[0];
    assign out1      = s3_reg[1];
    assign out2      = s3_reg[2];
    assign out3      = s3_reg[3];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pe_inv.sv
// Randomised and directed bench for pe_inv; a signed-integer reference model predicts every delivered beat.
module tb_pe_inv;
    localparam int WL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WL-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, twiddle = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WL-1:0] out0, out1, out2, out3;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    typedef struct packed {
        logic [63:0] o;     // {out3, out2, out1, out0}
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    bit          rnd_ovf = 0;
    bit          stall_prev = 0;
    logic [63:0] held = '0;

`ifdef PE_INV_SCALE_EN
    localparam logic [63:0] BASIC_EXP = 64'h8300_0000_8100_0400;
    localparam logic [15:0] SAT_OUT0  = 16'h7C00;
    localparam logic [15:0] SAT_OVF   = 16'd0;
    localparam logic [15:0] MUL_OUT0  = 16'h3FFF;
    localparam logic [15:0] MUL_OUT2  = 16'hBFFF;
`else
    localparam logic [63:0] BASIC_EXP = 64'h8600_0000_8200_0800;
    localparam logic [15:0] SAT_OUT0  = 16'h7FFF;
    localparam logic [15:0] SAT_OVF   = 16'd1;
    localparam logic [15:0] MUL_OUT0  = 16'h7FFF;
    localparam logic [15:0] MUL_OUT2  = 16'hFFFF;
`endif

    pe_inv #(.WL(16), .FWL(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .twiddle(twiddle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference arithmetic on plain signed integers (units of 2^-10).
    function automatic int to_int(input logic [15:0] w);
        int m = int'(w[14:0]);
        return w[15] ? -m : m;
    endfunction

    function automatic logic [15:0] to_word(input int v);
        int          m = (v < 0) ? -v : v;
        logic [15:0] w = 16'(m);
        w[15] = (v < 0);
        return w;
    endfunction

    function automatic int clip(input int v, inout bit f);
        if (v > 32767)  begin f = 1; return 32767;  end
        if (v < -32767) begin f = 1; return -32767; end
        return v;
    endfunction

    function automatic int mul_ref(input logic [15:0] a, input logic [15:0] b, inout bit f);
        int m = (int'(a[14:0]) * int'(b[14:0])) / 1024;
        if (m > 32767) begin f = 1; m = 32767; end
        return (a[15] ^ b[15]) ? -m : m;
    endfunction

    function automatic int add_ref(input int x, input int y, inout bit f);
`ifdef PE_INV_SCALE_EN
        return clip((x + y) / 2, f);    // integer division truncates toward zero, i.e. magnitude >> 1
`else
        return clip(x + y, f);
`endif
    endfunction

    function automatic exp_t model(input logic [15:0] a0, a1, a2, a3, tw);
        bit   f = 0;
        int   t1, t3;
        exp_t e;
        t1 = mul_ref(a1, tw, f);
        t3 = mul_ref(a3, tw, f);
        e.o = {to_word(add_ref(to_int(a2), -t3, f)), to_word(add_ref(to_int(a0), -t1, f)),
               to_word(add_ref(to_int(a2),  t3, f)), to_word(add_ref(to_int(a0),  t1, f))};
        e.ovf = f;
        return e;
    endfunction

    function automatic logic [15:0] rnd_word();
        logic [15:0] w = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       w[14:0]  = '0;
            1, 2, 3: w[14:11] = '0;
            default: ;
        endcase
        return w;
    endfunction

    // Single compare process: delivered beats, stall hold, and in_ready during stalls.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
                chk("stall_hold_data", {out3, out2, out1, out0}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_beat: got beat %h, required no beat pending",
                             {out3, out2, out1, out0});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {out3, out2, out1, out0}, e.o);
                    rnd_ovf |= e.ovf;
                    n_out++;
                end
            end
            if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
            stall_prev = out_valid && !out_ready;
            held       = {out3, out2, out1, out0};
            if (in_valid && in_ready) exp_q.push_back(model(in0, in1, in2, in3, twiddle));
        end
    end

    // Presents one beat from posedge+1 until accepted; returns at posedge+1 after the accepting edge.
    task automatic drive_beat(input logic [15:0] a0, a1, a2, a3, tw);
        bit acc = 0;
        int n = 0;
        in0 = a0; in1 = a1; in2 = a2; in3 = a3; twiddle = tw;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required acceptance");
        end
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got out_valid=0 after 50 cycles, required 1", tag);
        end
    endtask

    // Called in the cycle after acceptance on an empty pipeline: out_valid must rise in the third cycle.
    task automatic check_latency(input string tag);
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_lat3"}, 64'(out_valid), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   n0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", {out3, out2, out1, out0}, 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(1);

        // Hand-computed results pin the reference model.
        e = model(16'h0400, 16'h0800, 16'h8400, 16'h0400, 16'h0200);
        chk("model_basic", e.o, BASIC_EXP);
        e = model(16'h7C00, 16'h7C00, 16'h0000, 16'h0000, 16'h0400);
        chk("model_addsat", {e.o[47:32], e.o[15:0]}, {16'h0000, SAT_OUT0});
        e = model(16'h0000, 16'h7C00, 16'h0000, 16'h0000, 16'h0800);
        chk("model_mulovf", {e.o[47:32], e.o[15:0], 15'd0, e.ovf}, {MUL_OUT2, MUL_OUT0, 16'd1});

        // Basic beat with exact latency.
        drive_beat(16'h0400, 16'h0800, 16'h8400, 16'h0400, 16'h0200);
        check_latency("basic");
        chk("basic_out", {out3, out2, out1, out0}, BASIC_EXP);
        chk("basic_ovf", 64'(ovf), 64'd0);
        idle(3);

        // Add saturation, then ovf_clr.
        drive_beat(16'h7C00, 16'h7C00, 16'h0000, 16'h0000, 16'h0400);
        wait_out("addsat");
        chk("addsat_out0_out2", {out2, out0}, {16'h0000, SAT_OUT0});
        chk("addsat_ovf", 64'(ovf), 64'(SAT_OVF));
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);
        idle(2);

        // Multiply overflow; a second one coincides with ovf_clr.
        drive_beat(16'h0000, 16'h7C00, 16'h0000, 16'h0000, 16'h0800);
        wait_out("mulovf");
        chk("mulovf_out0_out2", {out2, out0}, {MUL_OUT2, MUL_OUT0});
        chk("mulovf_ovf", 64'(ovf), 64'd1);
        idle(2);
        drive_beat(16'h0000, 16'h7C00, 16'h0000, 16'h0000, 16'h0800);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", 64'(ovf), 64'd1);
        idle(4);

        // Backpressure: six distinct beats, out_ready low for five cycles mid-stream.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_beat(16'(16'h0100 * (i + 1)), 16'(16'h0040 * (i + 1)),
                               16'(16'h8080 + i), 16'h0200 + 16'(i), 16'h0300);
            end
            begin
                idle(2);
                out_ready = 1'b0;
                idle(5);
                out_ready = 1'b1;
            end
        join
        idle(8);
        chk("bp_delivered", 64'(n_out - n0), 64'd6);

        // Randomised traffic with random backpressure.
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        rnd_ovf = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in0 = rnd_word(); in1 = rnd_word(); in2 = rnd_word(); in3 = rnd_word();
            twiddle = rnd_word();
            idle(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        chk("rnd_ovf", 64'(ovf), 64'(rnd_ovf));

        // Reset with two beats in flight.
        drive_beat(16'h0000, 16'h7C00, 16'h0000, 16'h0000, 16'h0800);
        drive_beat(16'h0400, 16'h0800, 16'h8400, 16'h0400, 16'h0200);
        @(posedge clk);
        #2;
        chk("prereset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(out_valid), 64'd0);
        chk("midreset_outputs", {out3, out2, out1, out0}, 64'd0);
        chk("midreset_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("postreset_in_ready", 64'(in_ready), 64'd1);
        idle(1);
        drive_beat(16'h0400, 16'h0800, 16'h8400, 16'h0400, 16'h0200);
        check_latency("postreset");
        chk("postreset_out", {out3, out2, out1, out0}, BASIC_EXP);
        idle(5);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pe_inv.md
Name: pe_inv

Overview:
- Inverse radix-2 butterfly for the reconstruction (IFFT / decimation-in-time) direction; mirror of the forward PE.
- The forward PE adds and subtracts first, then multiplies by the twiddle. This block multiplies by the twiddle first, then adds and subtracts.
- Operands are sign-magnitude fixed point, the same format as qadd/qmult.
- Three-stage pipeline with valid/ready handshake on both sides. Sits between IFFT stage memories.

Parameters:
- WL, 16, total word length: 1 sign bit + (WL-1) magnitude bits.
- FWL, 10, fractional bits of the magnitude.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in0, in1, in2, in3  input  WL each  butterfly operands.
- twiddle  input  WL  real twiddle factor for this beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out0, out1, out2, out3  output  WL each  butterfly results.
- ovf  output  1  sticky overflow/saturation flag.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Number format:
  - value = (-1)^s * mag / 2^FWL, with s = bit WL-1 and mag = bits WL-2:0.
  - Every result of zero magnitude is emitted with s=0; no negative zero.
- Function (combinational intent):
  - t1 = in1*twiddle, t3 = in3*twiddle.
  - out0 = in0+t1, out1 = in2+t3, out2 = in0-t1, out3 = in2-t3.
  - Negation flips the sign bit only.
- Multiply:
  - sign = XOR of the operand signs.
  - magnitude = full (2*(WL-1))-bit product >> FWL, truncated.
  - If the result exceeds 2^(WL-1)-1, saturate to all-ones magnitude and flag overflow.
- Add:
  - Equal signs: add magnitudes; saturate at 2^(WL-1)-1 with overflow.
  - Unequal signs: larger magnitude minus smaller, taking the sign of the larger; equal magnitudes give +0.
- Pipeline:
  - S1: register inputs and twiddle.
  - S2: register t1, t3, and pass-through in0, in2.
  - S3: register the add/sub results, which drive out0..3.
  - Each stage carries a valid bit.
- Timing:
  - Latency is 3 cycles from the accepting edge (in_valid & in_ready) to out_valid, when not stalled.
  - Throughput is 1 beat per cycle.
- Stall:
  - en = !out_valid | out_ready; in_ready = en.
  - When en=0 all stages hold and outputs are stable.
  - Bubbles (invalid stages) advance normally when en=1.
- Handshake rules:
  - out0..3 change only when en=1.
  - A beat leaves on out_valid & out_ready.
  - Order is preserved; no beat is dropped or duplicated.
- ovf:
  - Set on any saturation in a stage that advances with a valid beat.
  - Cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
- Reset, asynchronous, including mid-operation:
  - All valid bits, data registers, out0..3 and ovf go to 0; out_valid=0.
  - in_ready=1 from the first cycle after release.
  - In-flight beats are discarded.

Optional Feature:
- Macro: PE_INV_SCALE_EN.
- When defined:
  - S3 computes the add/sub on a WL-bit magnitude (one guard bit), then shifts the magnitude right by 1 (truncate).
  - Each output is therefore (a±b)/2, which gives IFFT 1/N normalization per stage.
  - Add saturation cannot occur; only multiply overflow sets ovf.
- When undefined: unscaled outputs with add saturation as specified.
- Latency and handshake are identical either way.

Test Plan:
- Basic:
  - Stimulus: in0=0x0400, in1=0x0800, in2=0x8400, in3=0x0400, twiddle=0x0200, one beat, out_ready=1.
  - Response: exactly 3 cycles later, out0=0x0800, out1=0x8200, out2=0x0000, out3=0x8600, ovf=0.
- Backpressure:
  - Stimulus: stream 6 distinct beats with out_ready held 0 for 5 cycles mid-stream.
  - Response: in_ready=0 while out_valid=1 and out_ready=0; outputs stable during the stall; all 6 results delivered in order with none lost or duplicated.
- Add saturation:
  - Stimulus: in0=0x7C00, in1=0x7C00, twiddle=0x0400, in2=in3=0.
  - Response: out0=0x7FFF, out2=0x0000 (positive zero), ovf=1; ovf_clr pulse then returns ovf to 0.
- Multiply overflow:
  - Stimulus: in1=0x7C00, twiddle=0x0800, in0=0.
  - Response: out0=0x7FFF, out2=0xFFFF, ovf=1. Same cycle ovf_clr=1 with a new overflow leaves ovf=1.
- Reset mid-operation:
  - Stimulus: 2 beats in flight, then drive rst_n=0 for 1 cycle.
  - Response: out_valid=0, outputs=0 and ovf=0 immediately; after release, a new beat appears exactly 3 cycles after acceptance.
- Scaling (PE_INV_SCALE_EN defined):
  - Stimulus: stimulus of the basic scenario.
  - Response: out0=0x0400, out1=0x8100, out2=0x0000, out3=0x8300. With in0=in1=0x7C00 and twiddle=0x0400: out0=0x7C00, ovf=0.
